// File: rtl/c16_mem_arbiter_if.sv
// Bus bundle for c16_mem_arbiter: C16 core side, loader channel and external memory port.
interface c16_mem_arbiter_if #(parameter int ADDR_W = 18);
  logic              c16_strobe;
  logic [15:0]       c16_addr;
  logic              c16_rnw;
  logic [7:0]        c16_dout;
  logic              c16_cs_ram;
  logic              c16_cs0;
  logic              c16_cs1;
  logic [7:0]        c16_din;
  logic              inwait;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic              timeout_err;

  modport master (
    input  c16_strobe, c16_addr, c16_rnw, c16_dout, c16_cs_ram, c16_cs0, c16_cs1,
    input  dl_wr, dl_addr, dl_data, mem_rdata, mem_ready,
    output c16_din, inwait, dl_ack, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport slave (
    output c16_strobe, c16_addr, c16_rnw, c16_dout, c16_cs_ram, c16_cs0, c16_cs1,
    output dl_wr, dl_addr, dl_data, mem_rdata, mem_ready,
    input  c16_din, inwait, dl_ack, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/c16_mem_arbiter.sv
// Shares one memory port between C16 bus and loader; one access in flight, mem_req held until mem_ready or TIMEOUT.
// Optional C16_ROM_WP_EN: C16 writes to the cs0/cs1 ROM windows complete internally without a memory access.
module c16_mem_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int TIMEOUT     = 15,
  parameter int STALL_LIMIT = 4
) (
  input logic CLK28,
  input logic RESET,
  c16_mem_arbiter_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int ST_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, C16_ACC, DL_ACC} state_t;
  state_t state, state_n;

  logic              map_vld;
  logic [ADDR_W-1:0] map_addr;
  logic              cap;
  logic              pend_vld;
  logic              pend_rnw;
  logic              pend_clr;
  logic              pend_wp;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_data;
  logic [WD_W-1:0]   wd, wd_n;
  logic [ST_W-1:0]   stall, stall_n;
  logic              mem_req_n, mem_we_n, dl_ack_n, terr_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [7:0]        mem_wdata_n, din_n;

  always_comb begin
    map_vld = bus.c16_cs_ram | bus.c16_cs0 | bus.c16_cs1;
    if (bus.c16_cs_ram)   map_addr = ADDR_W'(bus.c16_addr);
    else if (bus.c16_cs0) map_addr = ADDR_W'({3'b100, bus.c16_addr[14:0]});
    else                  map_addr = ADDR_W'({3'b110, bus.c16_addr[14:0]});
  end

  assign cap        = bus.c16_strobe & map_vld;
  assign bus.inwait = (stall == ST_W'(STALL_LIMIT));

  // The slot is freed when its access launches, so a strobe arriving during that access stays queued.
  always_ff @(posedge CLK28) begin
    if (RESET) begin
      pend_vld  <= 1'b0;
      pend_rnw  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (cap) begin
      pend_vld  <= 1'b1;
      pend_rnw  <= bus.c16_rnw;
      pend_addr <= map_addr;
      pend_data <= bus.c16_dout;
    end else if (pend_clr) begin
      pend_vld  <= 1'b0;
    end
  end

`ifdef C16_ROM_WP_EN
  always_ff @(posedge CLK28) begin
    if (RESET)    pend_wp <= 1'b0;
    else if (cap) pend_wp <= ~bus.c16_cs_ram & ~bus.c16_rnw;
  end
`else
  assign pend_wp = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    mem_req_n   = bus.mem_req;
    mem_we_n    = bus.mem_we;
    mem_addr_n  = bus.mem_addr;
    mem_wdata_n = bus.mem_wdata;
    din_n       = bus.c16_din;
    dl_ack_n    = 1'b0;
    terr_n      = 1'b0;
    pend_clr    = 1'b0;
    wd_n        = '0;
    if (bus.c16_strobe) din_n = 8'hFF;
    case (state)
      IDLE: begin
        if (bus.dl_wr && (bus.inwait || !pend_vld)) begin
          state_n     = DL_ACC;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = bus.dl_addr;
          mem_wdata_n = bus.dl_data;
        end else if (pend_vld) begin
          pend_clr = 1'b1;
          if (pend_wp) begin
            din_n = 8'hFF;
          end else begin
            state_n     = C16_ACC;
            mem_req_n   = 1'b1;
            mem_we_n    = ~pend_rnw;
            mem_addr_n  = pend_addr;
            mem_wdata_n = pend_data;
          end
        end
      end
      C16_ACC, DL_ACC: begin
        wd_n = wd + 1'b1;
        if (bus.mem_ready) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          wd_n      = '0;
          if (state == C16_ACC) din_n = bus.mem_we ? 8'hFF : bus.mem_rdata;
          else                  dl_ack_n = 1'b1;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          wd_n      = '0;
          terr_n    = 1'b1;
          if (state == C16_ACC) din_n = 8'hFF;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Counts loader wait cycles; saturates at STALL_LIMIT, which is what raises inwait.
  always_comb begin
    stall_n = stall;
    if (state == DL_ACC && bus.mem_ready)
      stall_n = '0;
    else if (bus.dl_wr && state != DL_ACC && state_n != DL_ACC && !bus.inwait)
      stall_n = stall + 1'b1;
  end

  always_ff @(posedge CLK28) begin
    if (RESET) begin
      state           <= IDLE;
      wd              <= '0;
      stall           <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.c16_din     <= 8'hFF;
      bus.dl_ack      <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state           <= state_n;
      wd              <= wd_n;
      stall           <= stall_n;
      bus.mem_req     <= mem_req_n;
      bus.mem_we      <= mem_we_n;
      bus.mem_addr    <= mem_addr_n;
      bus.mem_wdata   <= mem_wdata_n;
      bus.c16_din     <= din_n;
      bus.dl_ack      <= dl_ack_n;
      bus.timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_c16_mem_arbiter.sv
// Self-checking bench for c16_mem_arbiter: directed scenarios plus a randomized run against a memory-image model.
module tb_c16_mem_arbiter;
  localparam int ADDR_W  = 18;
  localparam int TIMEOUT = 15;
  localparam int STALL   = 4;
  localparam int MSIZE   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c16_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  c16_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .STALL_LIMIT(STALL)) dut (
    .CLK28 (clk),
    .RESET (rst),
    .bus   (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem   [0:MSIZE-1];
  logic [7:0] model [0:MSIZE-1];
  bit auto_mem     = 1'b0;
  bit inject_ready = 1'b0;
  int mem_lat      = 3;
  int req_age      = 0;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7) ^ (a >> 9));
  endfunction

  // C16 window base addresses: RAM at 0, cs0 window at 128K, cs1 window at 192K, ROM windows 32K each.
  function automatic int map_c16(input int a, input int sel);
    if (sel == 0)      return a;
    else if (sel == 1) return 'h20000 + (a % 'h8000);
    else               return 'h30000 + (a % 'h8000);
  endfunction

  // One clock; the memory responder then prepares mem_ready for the next edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    if (inject_ready) begin
      bus.mem_ready = 1'b1;
      inject_ready  = 1'b0;
    end else if (auto_mem && bus.mem_req && !rst) begin
      req_age++;
      if (req_age >= mem_lat) begin
        bus.mem_ready = 1'b1;
        req_age       = 0;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else            bus.mem_rdata     = mem[bus.mem_addr];
      end
    end else begin
      req_age = 0;
    end
  endtask

  task automatic drive_strobe(input logic [15:0] a, input bit rnw, input logic [7:0] d,
                              input bit r, input bit s0, input bit s1);
    bus.c16_addr = a; bus.c16_rnw = rnw; bus.c16_dout = d;
    bus.c16_cs_ram = r; bus.c16_cs0 = s0; bus.c16_cs1 = s1;
    bus.c16_strobe = 1'b1;
    tick();
    bus.c16_strobe = 1'b0;
    bus.c16_cs_ram = 1'b0; bus.c16_cs0 = 1'b0; bus.c16_cs1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.mem_req !== 1'b0)    begin failures++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0)     begin failures++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 18'h0)  begin failures++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'h0)  begin failures++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
    checks++; if (bus.c16_din !== 8'hFF)   begin failures++; $display("FAIL rst_c16_din got %h want ff", bus.c16_din); end
    checks++; if (bus.inwait !== 1'b0)     begin failures++; $display("FAIL rst_inwait got %b want 0", bus.inwait); end
    checks++; if (bus.dl_ack !== 1'b0)     begin failures++; $display("FAIL rst_dl_ack got %b want 0", bus.dl_ack); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got %b want 0", bus.timeout_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_c16_read();
    bit done;
    auto_mem = 1'b1; mem_lat = 3;
    mem[18'h01234] = 8'hA5; model[18'h01234] = 8'hA5;
    drive_strobe(16'h1234, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (bus.mem_req !== 1'b1)      begin failures++; $display("FAIL rd_mem_req got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 18'h01234) begin failures++; $display("FAIL rd_mem_addr got %h want 01234", bus.mem_addr); end
    checks++; if (bus.mem_we !== 1'b0)       begin failures++; $display("FAIL rd_mem_we got %b want 0", bus.mem_we); end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (!bus.mem_req) done = 1'b1;
    end
    checks++; if (!done)                   begin failures++; $display("FAIL rd_complete got busy want done"); end
    checks++; if (bus.c16_din !== 8'hA5)   begin failures++; $display("FAIL rd_c16_din got %h want a5", bus.c16_din); end
    tick();
  endtask

  task automatic test_rom_write();
    int seen;
    auto_mem = 1'b1; mem_lat = 2;
    drive_strobe(16'hC000, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
`ifdef C16_ROM_WP_EN
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.mem_req) seen++;
    end
    checks++; if (seen != 0)             begin failures++; $display("FAIL wp_no_req got %0d req cycles want 0", seen); end
    checks++; if (bus.c16_din !== 8'hFF) begin failures++; $display("FAIL wp_c16_din got %h want ff", bus.c16_din); end
    checks++; if (mem[18'h34000] !== model[18'h34000]) begin failures++; $display("FAIL wp_mem got %h want %h", mem[18'h34000], model[18'h34000]); end
`else
    tick();
    checks++; if (bus.mem_req !== 1'b1)       begin failures++; $display("FAIL wr_mem_req got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 18'h34000) begin failures++; $display("FAIL wr_mem_addr got %h want 34000", bus.mem_addr); end
    checks++; if (bus.mem_we !== 1'b1)        begin failures++; $display("FAIL wr_mem_we got %b want 1", bus.mem_we); end
    checks++; if (bus.mem_wdata !== 8'h5A)    begin failures++; $display("FAIL wr_mem_wdata got %h want 5a", bus.mem_wdata); end
    seen = 0;
    for (int i = 0; i < 6; i++) tick();
    model[18'h34000] = 8'h5A;
    checks++; if (mem[18'h34000] !== 8'h5A) begin failures++; $display("FAIL wr_mem got %h want 5a", mem[18'h34000]); end
    checks++; if (bus.mem_req !== 1'b0)     begin failures++; $display("FAIL wr_req_drop got %b want 0", bus.mem_req); end
`endif
  endtask

  task automatic test_no_select();
    int seen;
    auto_mem = 1'b1; mem_lat = 2;
    drive_strobe(16'h0010, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checks++; if (bus.c16_din !== model[16]) begin failures++; $display("FAIL nsel_prep_din got %h want %h", bus.c16_din, model[16]); end
    drive_strobe(16'h0020, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.c16_din !== 8'hFF) begin failures++; $display("FAIL nsel_c16_din got %h want ff", bus.c16_din); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.mem_req) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL nsel_no_req got %0d req cycles want 0", seen); end
  endtask

  task automatic test_timeout();
    int hi; bit dropped; logic terr; logic [7:0] din;
    auto_mem = 1'b0;
    drive_strobe(16'h0042, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    hi = 0; dropped = 1'b0; terr = 1'b0; din = 8'h00;
    for (int i = 0; i < 30 && !dropped; i++) begin
      tick();
      if (bus.mem_req) hi++;
      else if (hi > 0) begin
        dropped = 1'b1; terr = bus.timeout_err; din = bus.c16_din;
      end
    end
    checks++; if (hi != TIMEOUT)   begin failures++; $display("FAIL to_req_cycles got %0d want %0d", hi, TIMEOUT); end
    checks++; if (terr !== 1'b1)   begin failures++; $display("FAIL to_err_pulse got %b want 1", terr); end
    checks++; if (din !== 8'hFF)   begin failures++; $display("FAIL to_c16_din got %h want ff", din); end
    tick();
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_one_cycle got %b want 0", bus.timeout_err); end
    checks++; if (bus.mem_req !== 1'b0)     begin failures++; $display("FAIL to_no_retry got %b want 0", bus.mem_req); end
  endtask

  task automatic test_stall();
    int t_rise, t_ack, acks, t_dl;
    bit prev_req, first_seen, first_we, inw_after;
    logic [ADDR_W-1:0] first_addr;
    auto_mem = 1'b1; mem_lat = 3;
    t_rise = -1; t_ack = -1; acks = 0; t_dl = 3;
    prev_req = 1'b0; first_seen = 1'b0; first_we = 1'b0; first_addr = '0; inw_after = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      if (t % 4 == 1 && t_ack < 0) begin
        bus.c16_addr = 16'(16'h0100 + t); bus.c16_rnw = 1'b1; bus.c16_cs_ram = 1'b1;
        bus.c16_strobe = 1'b1;
      end
      if (t == t_dl) begin
        bus.dl_wr = 1'b1; bus.dl_addr = 18'h00500; bus.dl_data = 8'h77;
      end
      tick();
      bus.c16_strobe = 1'b0; bus.c16_cs_ram = 1'b0;
      if (bus.inwait && t_rise < 0) t_rise = t;
      if (t_rise >= 0 && t > t_rise && !first_seen && bus.mem_req && !prev_req) begin
        first_seen = 1'b1; first_we = bus.mem_we; first_addr = bus.mem_addr;
      end
      prev_req = bus.mem_req;
      if (bus.dl_ack) begin
        acks++;
        if (t_ack < 0) t_ack = t;
        bus.dl_wr = 1'b0;
      end
      if (t_ack >= 0 && t == t_ack + 1) inw_after = bus.inwait;
    end
    model[18'h00500] = 8'h77;
    checks++; if (t_rise != t_dl + STALL - 1) begin failures++; $display("FAIL st_inwait_rise got tick %0d want %0d", t_rise, t_dl + STALL - 1); end
    checks++; if (!first_seen || first_we !== 1'b1 || first_addr !== 18'h00500)
      begin failures++; $display("FAIL st_next_grant got seen=%0b we=%b addr=%h want loader write to 00500", first_seen, first_we, first_addr); end
    checks++; if (acks != 1)          begin failures++; $display("FAIL st_ack_count got %0d want 1", acks); end
    checks++; if (inw_after !== 1'b0) begin failures++; $display("FAIL st_inwait_clear got %b want 0", inw_after); end
    checks++; if (mem[18'h00500] !== 8'h77) begin failures++; $display("FAIL st_mem got %h want 77", mem[18'h00500]); end
  endtask

  task automatic test_reset_mid_dl();
    int acks;
    auto_mem = 1'b0;
    bus.dl_wr = 1'b1; bus.dl_addr = 18'h00777; bus.dl_data = 8'h3C;
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 18'h00777 || bus.mem_we !== 1'b1)
      begin failures++; $display("FAIL rdl_grant got req=%b addr=%h we=%b want 1/00777/1", bus.mem_req, bus.mem_addr, bus.mem_we); end
    tick(); tick();
    rst = 1'b1; inject_ready = 1'b1;
    tick();
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 18'h0 || bus.c16_din !== 8'hFF || bus.inwait !== 1'b0)
      begin failures++; $display("FAIL rdl_reset_vals got req=%b addr=%h din=%h inwait=%b", bus.mem_req, bus.mem_addr, bus.c16_din, bus.inwait); end
    checks++; if (bus.dl_ack !== 1'b0) begin failures++; $display("FAIL rdl_ack_in_reset got %b want 0", bus.dl_ack); end
    rst = 1'b0;
    tick();
    checks++; if (bus.dl_ack !== 1'b0) begin failures++; $display("FAIL rdl_late_ready_ack got %b want 0", bus.dl_ack); end
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 18'h00777)
      begin failures++; $display("FAIL rdl_reissue got req=%b addr=%h want 1/00777", bus.mem_req, bus.mem_addr); end
    auto_mem = 1'b1; mem_lat = 2; acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.dl_ack) begin acks++; bus.dl_wr = 1'b0; end
    end
    model[18'h00777] = 8'h3C;
    checks++; if (acks != 1) begin failures++; $display("FAIL rdl_ack_count got %0d want 1", acks); end
    checks++; if (mem[18'h00777] !== 8'h3C) begin failures++; $display("FAIL rdl_mem got %h want 3c", mem[18'h00777]); end
  endtask

  task automatic test_random();
    int touched[$];
    int kind, sel, a, d, la, ma, acks;
    bit wp;
    auto_mem = 1'b1;
    for (int n = 0; n < 30; n++) begin
      mem_lat = $urandom_range(1, 5);
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 65535);
      d = $urandom_range(0, 255);
      if (kind == 2) begin
        la = $urandom_range(0, MSIZE - 1);
        bus.dl_wr = 1'b1; bus.dl_addr = 18'(la); bus.dl_data = 8'(d);
        acks = 0;
        for (int i = 0; i < 14; i++) begin
          tick();
          if (bus.dl_ack) begin acks++; bus.dl_wr = 1'b0; end
        end
        model[la] = 8'(d);
        touched.push_back(la);
        checks++; if (acks != 1) begin failures++; $display("FAIL rnd_dl_ack op=%0d got %0d want 1", n, acks); end
      end else begin
        sel = $urandom_range(0, 2);
        ma = map_c16(a, sel);
        bus.c16_addr = 16'(a); bus.c16_rnw = (kind == 0); bus.c16_dout = 8'(d);
        bus.c16_cs_ram = (sel == 0);
        bus.c16_cs0 = (sel == 1) || (sel == 0 && $urandom_range(0, 1) == 1);
        bus.c16_cs1 = (sel == 2) || ($urandom_range(0, 1) == 1);
        bus.c16_strobe = 1'b1;
        tick();
        bus.c16_strobe = 1'b0;
        bus.c16_cs_ram = 1'b0; bus.c16_cs0 = 1'b0; bus.c16_cs1 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        if (kind == 0) begin
          checks++; if (bus.c16_din !== model[ma]) begin failures++; $display("FAIL rnd_read op=%0d addr=%h got %h want %h", n, ma, bus.c16_din, model[ma]); end
        end else begin
`ifdef C16_ROM_WP_EN
          wp = (sel != 0);
`else
          wp = 1'b0;
`endif
          if (!wp) model[ma] = 8'(d);
          touched.push_back(ma);
        end
      end
    end
    for (int k = 0; k < touched.size(); k++) begin
      checks++;
      if (mem[touched[k]] !== model[touched[k]]) begin
        failures++; $display("FAIL rnd_mem addr=%h got %h want %h", touched[k], mem[touched[k]], model[touched[k]]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.c16_strobe = 1'b0; bus.c16_addr = '0; bus.c16_rnw = 1'b1; bus.c16_dout = '0;
    bus.c16_cs_ram = 1'b0; bus.c16_cs0 = 1'b0; bus.c16_cs1 = 1'b0;
    bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    for (int i = 0; i < MSIZE; i++) begin
      mem[i]   = init_val(i);
      model[i] = init_val(i);
    end
    test_reset();
    test_c16_read();
    test_rom_write();
    test_no_select();
    test_timeout();
    test_stall();
    test_reset_mid_dl();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
